// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-lite arbiter: one transaction in flight, round-robin grant, write before read.
// One cycle of arbitration in IDLE; all handshakes pass straight through to the granted master, the other master waits.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0 (core data port)
  input  logic              m0_awvalid,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [2:0]        m0_awprot,
  output logic              m0_awready,
  input  logic              m0_wvalid,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_wready,
  output logic              m0_bvalid,
  output logic [1:0]        m0_bresp,
  input  logic              m0_bready,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [2:0]        m0_arprot,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  // master 1 (debug / DMA port)
  input  logic              m1_awvalid,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [2:0]        m1_awprot,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  input  logic              m1_bready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [2:0]        m1_arprot,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  // shared slave
  output logic              s_awvalid,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [2:0]        s_awprot,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  output logic              s_bready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arprot,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready,
  // status
  output logic              grant_id,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   grant_nxt, prio, prio_nxt;
  logic   aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic   req0, req1, pick, aw_hs, w_hs;

  // granted master's request-side signals
  logic              sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [ADDR_W-1:0] sel_awaddr, sel_araddr;
  logic [2:0]        sel_awprot, sel_arprot;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  // response-side signals destined for the granted master
  logic              g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [1:0]        g_bresp, g_rresp;
  logic [DATA_W-1:0] g_rdata;

  assign req0 = m0_awvalid | m0_arvalid;
  assign req1 = m1_awvalid | m1_arvalid;

  assign sel_awvalid = grant_id ? m1_awvalid : m0_awvalid;
  assign sel_awaddr  = grant_id ? m1_awaddr  : m0_awaddr;
  assign sel_awprot  = grant_id ? m1_awprot  : m0_awprot;
  assign sel_wvalid  = grant_id ? m1_wvalid  : m0_wvalid;
  assign sel_wdata   = grant_id ? m1_wdata   : m0_wdata;
  assign sel_wstrb   = grant_id ? m1_wstrb   : m0_wstrb;
  assign sel_bready  = grant_id ? m1_bready  : m0_bready;
  assign sel_arvalid = grant_id ? m1_arvalid : m0_arvalid;
  assign sel_araddr  = grant_id ? m1_araddr  : m0_araddr;
  assign sel_arprot  = grant_id ? m1_arprot  : m0_arprot;
  assign sel_rready  = grant_id ? m1_rready  : m0_rready;

  assign busy = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      grant_id <= 1'b0;
      prio     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      prio     <= prio_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    prio_nxt    = prio;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    pick        = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    s_awvalid   = 1'b0;
    s_awaddr    = '0;
    s_awprot    = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arprot    = '0;
    s_rready    = 1'b0;
    g_awready   = 1'b0;
    g_wready    = 1'b0;
    g_bvalid    = 1'b0;
    g_bresp     = '0;
    g_arready   = 1'b0;
    g_rvalid    = 1'b0;
    g_rdata     = '0;
    g_rresp     = '0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          pick      = (req0 & req1) ? prio : req1;
          grant_nxt = pick;
          state_nxt = (pick ? m1_awvalid : m0_awvalid) ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        s_awvalid = sel_awvalid & ~aw_done;
        s_awaddr  = sel_awaddr;
        s_awprot  = sel_awprot;
        s_wvalid  = sel_wvalid & ~w_done;
        s_wdata   = sel_wdata;
        s_wstrb   = sel_wstrb;
        g_awready = s_awready & ~aw_done;
        g_wready  = s_wready & ~w_done;
        aw_hs     = s_awvalid & s_awready;
        w_hs      = s_wvalid & s_wready;
        // AW and W may finish in either order or together
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end

      WR_RESP: begin
        s_bready = sel_bready;
        g_bvalid = s_bvalid;
        g_bresp  = s_bresp;
        if (s_bvalid & sel_bready) begin
          state_nxt = IDLE;
          prio_nxt  = ~grant_id;
        end
      end

      RD_REQ: begin
        s_arvalid = sel_arvalid;
        s_araddr  = sel_araddr;
        s_arprot  = sel_arprot;
        g_arready = s_arready;
        if (sel_arvalid & s_arready) state_nxt = RD_RESP;
      end

      RD_RESP: begin
        s_rready = sel_rready;
        g_rvalid = s_rvalid;
        g_rdata  = s_rdata;
        g_rresp  = s_rresp;
        if (s_rvalid & sel_rready) begin
          state_nxt = IDLE;
          prio_nxt  = ~grant_id;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // the non-granted master only ever sees zeros
  assign m0_awready = g_awready & ~grant_id;
  assign m1_awready = g_awready &  grant_id;
  assign m0_wready  = g_wready  & ~grant_id;
  assign m1_wready  = g_wready  &  grant_id;
  assign m0_bvalid  = g_bvalid  & ~grant_id;
  assign m1_bvalid  = g_bvalid  &  grant_id;
  assign m0_bresp   = grant_id ? 2'b00 : g_bresp;
  assign m1_bresp   = grant_id ? g_bresp : 2'b00;
  assign m0_arready = g_arready & ~grant_id;
  assign m1_arready = g_arready &  grant_id;
  assign m0_rvalid  = g_rvalid  & ~grant_id;
  assign m1_rvalid  = g_rvalid  &  grant_id;
  assign m0_rdata   = grant_id ? '0 : g_rdata;
  assign m1_rdata   = grant_id ? g_rdata : '0;
  assign m0_rresp   = grant_id ? 2'b00 : g_rresp;
  assign m1_rresp   = grant_id ? g_rresp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: reactive slave/master model plus per-scenario scoreboard checks.
module tb_axi_lite_arbiter_2to1;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [2:0]  m0_awprot, m0_arprot;
  logic [3:0]  m0_wstrb;
  logic [1:0]  m0_bresp, m0_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [2:0]  m1_awprot, m1_arprot;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp, m1_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        grant_id, busy;

  typedef logic [67:0] wr_t;   // {addr, data, strb} seen by the slave
  typedef logic [34:0] r_t;    // {id, rresp, rdata} seen by a master
  typedef logic [2:0]  b_t;    // {id, bresp} seen by a master

  wr_t exp_w[$], wr_obs[$];
  r_t  exp_r[$], r_obs[$];
  b_t  exp_b[$], b_obs[$];

  int checks = 0, passed = 0, cyc = 0, last_b_cyc = 0, last_r_cyc = 0;

  axi_lite_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h1234_5678;
      32'h24:  return 32'h9ABC_DEF0;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return (a[5:4] == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  // Handshakes are sampled at negedge (inputs are stable there) and acted on just after posedge.
  initial begin
    bit m0aw, m0w, m0ar, m1aw, m1w, m1ar, sb, sr, in_rst, got_aw, got_w, got_ar;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
    logic [3:0]  sl_wstrb;
    got_aw = 0; got_w = 0; got_ar = 0;
    sl_awaddr = '0; sl_wdata = '0; sl_araddr = '0; sl_wstrb = '0;
    forever begin
      @(negedge ACLK);
      in_rst = !ARESETn;
      m0aw = m0_awvalid && m0_awready; m0w = m0_wvalid && m0_wready; m0ar = m0_arvalid && m0_arready;
      m1aw = m1_awvalid && m1_awready; m1w = m1_wvalid && m1_wready; m1ar = m1_arvalid && m1_arready;
      sb = s_bvalid && s_bready; sr = s_rvalid && s_rready;
      if (s_awvalid && s_awready) begin sl_awaddr = s_awaddr; got_aw = 1; end
      if (s_wvalid && s_wready) begin sl_wdata = s_wdata; sl_wstrb = s_wstrb; got_w = 1; end
      if (s_arvalid && s_arready) begin sl_araddr = s_araddr; got_ar = 1; end
      if (m0_bvalid && m0_bready) begin b_obs.push_back({1'b0, m0_bresp}); last_b_cyc = cyc; end
      if (m1_bvalid && m1_bready) begin b_obs.push_back({1'b1, m1_bresp}); last_b_cyc = cyc; end
      if (m0_rvalid && m0_rready) begin r_obs.push_back({1'b0, m0_rresp, m0_rdata}); last_r_cyc = cyc; end
      if (m1_rvalid && m1_rready) begin r_obs.push_back({1'b1, m1_rresp, m1_rdata}); last_r_cyc = cyc; end
      @(posedge ACLK);
      cyc++;
      #1;
      if (m0aw) m0_awvalid = 0;
      if (m0w)  m0_wvalid = 0;
      if (m0ar) m0_arvalid = 0;
      if (m1aw) m1_awvalid = 0;
      if (m1w)  m1_wvalid = 0;
      if (m1ar) m1_arvalid = 0;
      if (sb) s_bvalid = 0;
      if (sr) s_rvalid = 0;
      if (in_rst) begin
        got_aw = 0; got_w = 0; got_ar = 0; s_bvalid = 0; s_rvalid = 0;
      end else begin
        if (got_aw && got_w && !s_bvalid) begin
          s_bvalid = 1; s_bresp = resp_for(sl_awaddr);
          wr_obs.push_back({sl_awaddr, sl_wdata, sl_wstrb});
          got_aw = 0; got_w = 0;
        end
        if (got_ar && !s_rvalid) begin
          s_rvalid = 1; s_rdata = rdata_for(sl_araddr); s_rresp = resp_for(sl_araddr);
          got_ar = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_write(input bit id, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (id) begin
      m1_awvalid = 1; m1_awaddr = a; m1_awprot = 3'b010; m1_wvalid = 1; m1_wdata = d; m1_wstrb = st;
    end else begin
      m0_awvalid = 1; m0_awaddr = a; m0_awprot = 3'b001; m0_wvalid = 1; m0_wdata = d; m0_wstrb = st;
    end
  endtask

  task automatic drive_read(input bit id, input logic [31:0] a);
    if (id) begin m1_arvalid = 1; m1_araddr = a; m1_arprot = 3'b010; end
    else    begin m0_arvalid = 1; m0_araddr = a; m0_arprot = 3'b001; end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (!busy && !m0_awvalid && !m0_wvalid && !m0_arvalid && !m1_awvalid && !m1_wvalid &&
          !m1_arvalid && !s_bvalid && !s_rvalid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ARESETn = 0;
    repeat (3) tick();
    @(negedge ACLK);
    checks++; if ({busy, grant_id, dut.prio, dut.aw_done, dut.w_done} !== 5'b0)
      $display("FAIL reset_state: got %b want 00000", {busy, grant_id, dut.prio, dut.aw_done, dut.w_done}); else passed++;
    checks++; if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'b0)
      $display("FAIL reset_slave_ctl: got %b want 00000", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}); else passed++;
    checks++; if ({m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid,
                   m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid} !== 10'b0)
      $display("FAIL reset_master_ctl: got %b want 0", {m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid,
                                                         m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid}); else passed++;
    checks++; if ({s_awaddr, s_wdata, s_araddr} !== 96'b0)
      $display("FAIL reset_data: got %h want 0", {s_awaddr, s_wdata, s_araddr}); else passed++;
    tick();
    ARESETn = 1;
  endtask

  task automatic test_rr_read();
    bit m1_seen, got0, ok;
    r_t er, orv;
    exp_r.push_back({1'b0, 2'b00, 32'h1234_5678});
    exp_r.push_back({1'b1, 2'b00, 32'h9ABC_DEF0});
    tick();
    drive_read(0, 32'h20);
    drive_read(1, 32'h24);
    m1_seen = 0; got0 = 0;
    for (int i = 0; i < 20 && !got0; i++) begin
      @(negedge ACLK);
      if (m1_arready || m1_rvalid) m1_seen = 1;
      if (m0_rvalid && m0_rready) got0 = 1;
    end
    checks++; if (got0 !== 1'b1) $display("FAIL rr_read m0_done: got %b want 1", got0); else passed++;
    checks++; if (m1_seen !== 1'b0) $display("FAIL rr_read m1_blocked: got %b want 0", m1_seen); else passed++;
    wait_idle(40, ok);
    checks++; if (ok !== 1'b1) $display("FAIL rr_read idle_timeout: got %b want 1", ok); else passed++;
    repeat (exp_r.size()) begin
      er = exp_r.pop_front(); orv = '0;
      if (r_obs.size() > 0) orv = r_obs.pop_front();
      checks++; if (orv !== er) $display("FAIL rr_read rdata: got %h want %h", orv, er); else passed++;
    end
  endtask

  task automatic test_single_write();
    bit ok;
    wr_t ew, ow;
    b_t eb, ob;
    exp_w.push_back({32'h10, 32'hA5A5_0001, 4'hF});
    exp_b.push_back(3'b000);
    tick();
    drive_write(0, 32'h10, 32'hA5A5_0001, 4'hF);
    @(negedge ACLK);
    checks++; if ({busy, s_awvalid, s_wvalid, m0_awready, m0_wready} !== 5'b0)
      $display("FAIL write idle_no_ready: got %b want 00000", {busy, s_awvalid, s_wvalid, m0_awready, m0_wready}); else passed++;
    @(negedge ACLK);
    checks++; if ({busy, grant_id, s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata} !==
                  {1'b1, 1'b0, 1'b1, 32'h10, 3'b001, 1'b1, 32'hA5A5_0001})
      $display("FAIL write first_slave_cycle: got %h want %h", {busy, grant_id, s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata},
               {1'b1, 1'b0, 1'b1, 32'h10, 3'b001, 1'b1, 32'hA5A5_0001}); else passed++;
    wait_idle(30, ok);
    checks++; if (ok !== 1'b1) $display("FAIL write idle_timeout: got %b want 1", ok); else passed++;
    repeat (exp_w.size()) begin
      ew = exp_w.pop_front(); ow = '0;
      if (wr_obs.size() > 0) ow = wr_obs.pop_front();
      checks++; if (ow !== ew) $display("FAIL write slave_write: got %h want %h", ow, ew); else passed++;
    end
    repeat (exp_b.size()) begin
      eb = exp_b.pop_front(); ob = '1;
      if (b_obs.size() > 0) ob = b_obs.pop_front();
      checks++; if (ob !== eb) $display("FAIL write bresp: got %b want %b", ob, eb); else passed++;
    end
    checks++; if (dut.prio !== 1'b1) $display("FAIL write prio_after_m0: got %b want 1", dut.prio); else passed++;
  endtask

  task automatic test_wr_then_rd();
    bit ok;
    wr_t ew, ow;
    b_t eb, ob;
    r_t er, orv;
    exp_w.push_back({32'h30, 32'h5555_AAAA, 4'h3});
    exp_b.push_back({1'b1, 2'b10});
    exp_r.push_back({1'b1, 2'b10, 32'hC0DE_0034});
    tick();
    drive_write(1, 32'h30, 32'h5555_AAAA, 4'h3);
    drive_read(1, 32'h34);
    wait_idle(60, ok);
    checks++; if (ok !== 1'b1) $display("FAIL wr_then_rd idle_timeout: got %b want 1", ok); else passed++;
    checks++; if (!(last_b_cyc < last_r_cyc))
      $display("FAIL wr_then_rd order: b at %0d, r at %0d, want b first", last_b_cyc, last_r_cyc); else passed++;
    repeat (exp_w.size()) begin
      ew = exp_w.pop_front(); ow = '0;
      if (wr_obs.size() > 0) ow = wr_obs.pop_front();
      checks++; if (ow !== ew) $display("FAIL wr_then_rd slave_write: got %h want %h", ow, ew); else passed++;
    end
    repeat (exp_b.size()) begin
      eb = exp_b.pop_front(); ob = '0;
      if (b_obs.size() > 0) ob = b_obs.pop_front();
      checks++; if (ob !== eb) $display("FAIL wr_then_rd bresp: got %b want %b", ob, eb); else passed++;
    end
    repeat (exp_r.size()) begin
      er = exp_r.pop_front(); orv = '0;
      if (r_obs.size() > 0) orv = r_obs.pop_front();
      checks++; if (orv !== er) $display("FAIL wr_then_rd rdata: got %h want %h", orv, er); else passed++;
    end
  endtask

  task automatic test_split_write();
    bit ok;
    wr_t ew, ow;
    b_t eb, ob;
    // W held off three cycles after AW is accepted
    exp_w.push_back({32'h44, 32'hDEAD_BEEF, 4'hC});
    exp_b.push_back(3'b000);
    s_wready = 0;
    tick();
    drive_write(0, 32'h44, 32'hDEAD_BEEF, 4'hC);
    repeat (3) @(negedge ACLK);
    checks++; if ({s_awvalid, m0_awready, dut.aw_done, s_wvalid, m0_wready, busy} !== 6'b001101)
      $display("FAIL split aw_done_hold: got %b want 001101", {s_awvalid, m0_awready, dut.aw_done, s_wvalid, m0_wready, busy}); else passed++;
    repeat (2) @(negedge ACLK);
    tick();
    s_wready = 1;
    wait_idle(30, ok);
    checks++; if (ok !== 1'b1) $display("FAIL split aw_first_timeout: got %b want 1", ok); else passed++;
    // AW held off: W completes first
    exp_w.push_back({32'h48, 32'h0BAD_F00D, 4'h1});
    exp_b.push_back(3'b100);
    s_awready = 0;
    tick();
    drive_write(1, 32'h48, 32'h0BAD_F00D, 4'h1);
    repeat (3) @(negedge ACLK);
    checks++; if ({s_wvalid, m1_wready, dut.w_done, s_awvalid, m1_awready, grant_id} !== 6'b001101)
      $display("FAIL split w_done_hold: got %b want 001101", {s_wvalid, m1_wready, dut.w_done, s_awvalid, m1_awready, grant_id}); else passed++;
    tick();
    s_awready = 1;
    wait_idle(30, ok);
    checks++; if (ok !== 1'b1) $display("FAIL split w_first_timeout: got %b want 1", ok); else passed++;
    repeat (exp_w.size()) begin
      ew = exp_w.pop_front(); ow = '0;
      if (wr_obs.size() > 0) ow = wr_obs.pop_front();
      checks++; if (ow !== ew) $display("FAIL split slave_write: got %h want %h", ow, ew); else passed++;
    end
    repeat (exp_b.size()) begin
      eb = exp_b.pop_front(); ob = '1;
      if (b_obs.size() > 0) ob = b_obs.pop_front();
      checks++; if (ob !== eb) $display("FAIL split bresp: got %b want %b", ob, eb); else passed++;
    end
    checks++; if (b_obs.size() + wr_obs.size() != 0)
      $display("FAIL split extra_resp: got %0d want 0", b_obs.size() + wr_obs.size()); else passed++;
  endtask

  task automatic test_rready_hold();
    bit ok, found;
    r_t er, orv;
    exp_r.push_back({1'b0, 2'b00, 32'h1234_5678});
    m0_rready = 0;
    tick();
    drive_read(0, 32'h20);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ACLK);
      if (m0_rvalid) found = 1;
    end
    checks++; if (found !== 1'b1) $display("FAIL rready_hold rvalid_timeout: got %b want 1", found); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checks++; if ({m0_rvalid, m0_rdata, s_rready, busy} !== {1'b1, 32'h1234_5678, 1'b0, 1'b1})
        $display("FAIL rready_hold stall%0d: got %h want %h", i, {m0_rvalid, m0_rdata, s_rready, busy},
                 {1'b1, 32'h1234_5678, 1'b0, 1'b1}); else passed++;
    end
    tick();
    m0_rready = 1;
    wait_idle(20, ok);
    checks++; if (ok !== 1'b1) $display("FAIL rready_hold idle_timeout: got %b want 1", ok); else passed++;
    repeat (exp_r.size()) begin
      er = exp_r.pop_front(); orv = '0;
      if (r_obs.size() > 0) orv = r_obs.pop_front();
      checks++; if (orv !== er) $display("FAIL rready_hold rdata: got %h want %h", orv, er); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    wr_t ew, ow;
    r_t er, orv;
    exp_w.push_back({32'h50, 32'h00C0_FFEE, 4'hF});
    m0_bready = 0;
    tick();
    drive_write(0, 32'h50, 32'h00C0_FFEE, 4'hF);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ACLK);
      if (m0_bvalid) found = 1;
    end
    checks++; if (found !== 1'b1) $display("FAIL reset_mid bvalid_timeout: got %b want 1", found); else passed++;
    tick();
    ARESETn = 0;
    tick();
    ARESETn = 1;
    m0_bready = 1;
    @(negedge ACLK);
    checks++; if ({busy, grant_id, dut.prio, s_bready, s_bvalid, m0_bvalid, s_awvalid, s_wvalid, s_arvalid, s_rready} !== 10'b0)
      $display("FAIL reset_mid after_reset: got %b want 0", {busy, grant_id, dut.prio, s_bready, s_bvalid, m0_bvalid,
                                                             s_awvalid, s_wvalid, s_arvalid, s_rready}); else passed++;
    repeat (exp_w.size()) begin
      ew = exp_w.pop_front(); ow = '0;
      if (wr_obs.size() > 0) ow = wr_obs.pop_front();
      checks++; if (ow !== ew) $display("FAIL reset_mid slave_write: got %h want %h", ow, ew); else passed++;
    end
    checks++; if (b_obs.size() != 0) $display("FAIL reset_mid abandoned_b: got %0d want 0", b_obs.size()); else passed++;
    exp_r.push_back({1'b1, 2'b00, 32'h9ABC_DEF0});
    tick();
    drive_read(1, 32'h24);
    repeat (2) @(negedge ACLK);
    checks++; if ({busy, grant_id, s_arvalid, s_araddr, s_arprot} !== {1'b1, 1'b1, 1'b1, 32'h24, 3'b010})
      $display("FAIL reset_mid m1_grant: got %h want %h", {busy, grant_id, s_arvalid, s_araddr, s_arprot},
               {1'b1, 1'b1, 1'b1, 32'h24, 3'b010}); else passed++;
    wait_idle(20, ok);
    checks++; if (ok !== 1'b1) $display("FAIL reset_mid idle_timeout: got %b want 1", ok); else passed++;
    repeat (exp_r.size()) begin
      er = exp_r.pop_front(); orv = '0;
      if (r_obs.size() > 0) orv = r_obs.pop_front();
      checks++; if (orv !== er) $display("FAIL reset_mid rdata: got %h want %h", orv, er); else passed++;
    end
  endtask

  initial begin
    ARESETn = 0;
    m0_awvalid = 0; m0_awaddr = '0; m0_awprot = '0; m0_wvalid = 0; m0_wdata = '0; m0_wstrb = '0;
    m0_bready = 1; m0_arvalid = 0; m0_araddr = '0; m0_arprot = '0; m0_rready = 1;
    m1_awvalid = 0; m1_awaddr = '0; m1_awprot = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
    m1_bready = 1; m1_arvalid = 0; m1_araddr = '0; m1_arprot = '0; m1_rready = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    s_bvalid = 0; s_bresp = '0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    test_reset();
    test_rr_read();
    test_single_write();
    test_wr_then_rd();
    test_split_write();
    test_rready_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Shares one AXI4-lite slave (e.g. peripheral/IP register bridge) between two AXI4-lite masters: M0 = core data port, M1 = debug/DMA port.
- One transaction in flight at a time; round-robin between masters; write-before-read within a master.
- Sits between the bus masters and the slave bridge; purely a sequencer/mux, no data buffering.

Parameters:
- ADDR_W, 32, AXI address width (matches `AXI_ADDR_WIDTH)
- DATA_W, 32, AXI data width (matches `AXI_DATA_WIDTH)
- STRB_W, DATA_W/8, write strobe width

Ports:
- ACLK  in  1  single clock, all logic on rising edge
- ARESETn  in  1  synchronous, active-low reset
- mN_awvalid, mN_awaddr, mN_awprot (N=0,1)  in  1/ADDR_W/3  master write address
- mN_awready  out  1  write address accepted
- mN_wvalid, mN_wdata, mN_wstrb  in  1/DATA_W/STRB_W  master write data
- mN_wready  out  1  write data accepted
- mN_bvalid, mN_bresp  out  1/2  write response to master
- mN_bready  in  1  master accepts response
- mN_arvalid, mN_araddr, mN_arprot  in  1/ADDR_W/3  master read address
- mN_arready  out  1  read address accepted
- mN_rvalid, mN_rdata, mN_rresp  out  1/DATA_W/2  read data to master
- mN_rready  in  1  master accepts read data
- s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr, s_arprot, s_rready  out  (widths as master side)  to slave
- s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp  in  (widths as master side)  from slave
- grant_id  out  1  owner of current transaction (debug/status)
- busy  out  1  high in any state except IDLE

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. Registers: state, grant_id, prio (next preferred master), aw_done, w_done.
- Reset (ARESETn=0 at posedge, any state): state=IDLE, grant_id=0, prio=0, aw_done=w_done=0. All s_*valid, s_bready, s_rready, mN_*ready, mN_bvalid, mN_rvalid = 0. Address/data outputs = 0. In-flight transaction is abandoned; the bench must reset the slave alongside.
- reqN = mN_awvalid | mN_arvalid.
- IDLE: if neither reqN, stay. If only one, grant it. If both, grant prio. Write if granted master's awvalid, else read. Next state WR_REQ/RD_REQ; grant_id registered. No master ready is asserted in IDLE. First slave valid appears the cycle after the request is seen (1-cycle arbitration latency).
- WR_REQ: s_awvalid = m[g]_awvalid & !aw_done; s_wvalid = m[g]_wvalid & !w_done. Address, prot, data and strb are muxed from grant_id.
  - m[g]_awready = s_awready & !aw_done; m[g]_wready = s_wready & !w_done.
  - Set aw_done/w_done on the respective handshake; AW and W may complete in either order or the same cycle.
  - When both are done (including same-cycle completion), go to WR_RESP and clear both flags.
- WR_RESP: s_bready = m[g]_bready; m[g]_bvalid = s_bvalid; bresp passed through. On s_bvalid & m[g]_bready, go to IDLE with prio = ~grant_id. A slave that raises bvalid while still in WR_REQ (e.g. B one cycle after W) is held: s_bready=0 until WR_RESP, so no response is lost.
- RD_REQ: s_arvalid = m[g]_arvalid; m[g]_arready = s_arready; on the handshake go to RD_RESP.
- RD_RESP: m[g]_rvalid = s_rvalid; rdata/rresp pass through; s_rready = m[g]_rready. On the handshake, go to IDLE with prio = ~grant_id.
- Non-granted master: all readies and valids held 0 in every state; its requests wait, never dropped.
- A granted master deasserting awvalid/arvalid before the handshake is illegal AXI; the FSM holds its state (no timeout).
- Throughput: minimum 1 idle cycle between transactions (IDLE is a real state). Back-to-back requests alternate masters.

Test Plan:
- M0 write addr 0x10 data 0xA5A5_0001 strb 0xF; slave AW/W ready=1, B one cycle later → s_awaddr=0x10 one cycle after request, m0_bvalid=1 with bresp=00, busy returns low, prio=1.
- M0 read and M1 read issued the same cycle, prio=0 → M0 served first (rdata 0x1234_5678), then M1 (0x9ABC_DEF0); m1_arready stays 0 throughout M0's transaction.
- M1 with awvalid and arvalid both high → write executes first, read follows in a later grant; both complete.
- Slave wready delayed 3 cycles after awready → aw_done holds, s_awvalid drops after accept, single B returned; also cover AW and W completing in the same cycle.
- m0_rready held low 4 cycles while s_rvalid=1 → data stable at m0_rdata, state stays RD_RESP, s_rready=0 until m0_rready rises.
- ARESETn low during WR_RESP → next cycle state=IDLE, busy=0, all valids/readies 0, prio=0; a subsequent M1 request is granted normally.
